bram_fill_controller: RTL and testbench

- Downstream consumer of the DRAM-to-memory packer.
- Takes each packed wide word and its write strobe, then writes it into a set of interleaved on-chip BRAM banks.
- Word k goes to bank k mod NUM_BANKS, address k / NUM_BANKS.
- A start/done handshake brackets one load of a programmable number of words, such as a weight or feature-map tile.

---
 rtl/bram_fill_controller_pkg.sv | 27 ++
 rtl/bram_fill_controller_if.sv | 45 ++++
 rtl/bram_interleave_addr_gen.sv | 54 +++++
 rtl/bram_fill_controller.sv | 125 ++++++++++++
 tb/tb_bram_fill_controller.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/bram_fill_controller_pkg.sv
// Shared types and constants for the BRAM fill stage (also used by the packer for the word width).
// Optional feature macro used by this block: FILL_COUNT_EN.
package bram_fill_controller_pkg;

  localparam int DEFAULT_DATA_BITWIDTH = 163;
  localparam int DEFAULT_ADDR_BITWIDTH = 10;
  localparam int DEFAULT_NUM_BANKS     = 4;

  localparam int BANK_SEL_BITWIDTH = $clog2(DEFAULT_NUM_BANKS);
  localparam int WORD_CNT_BITWIDTH = DEFAULT_ADDR_BITWIDTH + BANK_SEL_BITWIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  function automatic int bank_sel_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  // One spare bit so a full-capacity load count never wraps.
  function automatic int word_cnt_bits(input int addr_bits, input int num_banks);
    return addr_bits + $clog2(num_banks) + 1;
  endfunction

endpackage

// File: rtl/bram_fill_controller_if.sv
// Load-control, packer-word and BRAM-write signals of the fill controller.
// Carries words_written_o only when FILL_COUNT_EN is defined.
interface bram_fill_controller_if
  import bram_fill_controller_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH,
  parameter int NUM_BANKS     = DEFAULT_NUM_BANKS
);
  localparam int CNT_W = word_cnt_bits(ADDR_BITWIDTH, NUM_BANKS);

  // Handshake: word_valid_i is a push-only strobe with no ready; every valid word seen in FILL
  // is written one cycle later, valid words outside FILL are dropped and flagged on err_o.
  // start_i is only sampled in IDLE; done_o is a single-cycle pulse.
  logic                     start_i;
  logic [CNT_W-1:0]         total_words_i;
  logic [DATA_BITWIDTH-1:0] word_i;
  logic                     word_valid_i;
  logic [DATA_BITWIDTH-1:0] bram_data_o;
  logic [ADDR_BITWIDTH-1:0] bram_addr_o;
  logic [NUM_BANKS-1:0]     bram_we_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;
`ifdef FILL_COUNT_EN
  logic [CNT_W-1:0]         words_written_o;
`endif

  modport master (
    output start_i, total_words_i, word_i, word_valid_i,
`ifdef FILL_COUNT_EN
    input  words_written_o,
`endif
    input  bram_data_o, bram_addr_o, bram_we_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, total_words_i, word_i, word_valid_i,
`ifdef FILL_COUNT_EN
    output words_written_o,
`endif
    output bram_data_o, bram_addr_o, bram_we_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/bram_interleave_addr_gen.sv
// Interleaved bank/address counters: word k maps to bank k mod NUM_BANKS, address k / NUM_BANKS.
module bram_interleave_addr_gen
  import bram_fill_controller_pkg::*;
#(
  parameter int ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH,
  parameter int NUM_BANKS     = DEFAULT_NUM_BANKS,
  localparam int BSEL_W       = bank_sel_bits(NUM_BANKS)
) (
  input  logic                     clk_i,
  input  logic                     dram_to_mem_rst_i,
  input  logic                     clear_i,
  input  logic                     advance_i,
  output logic [BSEL_W-1:0]        bank_idx_o,
  output logic [ADDR_BITWIDTH-1:0] addr_cnt_o,
  output logic [NUM_BANKS-1:0]     bank_onehot_o
);

  logic [BSEL_W-1:0]        bank_idx_q, bank_idx_d;
  logic [ADDR_BITWIDTH-1:0] addr_cnt_q, addr_cnt_d;

  // NUM_BANKS is a power of two, so the bank index wraps by plain overflow.
  always_comb begin
    bank_idx_d = bank_idx_q;
    addr_cnt_d = addr_cnt_q;
    if (clear_i) begin
      bank_idx_d = '0;
      addr_cnt_d = '0;
    end else if (advance_i) begin
      bank_idx_d = bank_idx_q + 1'b1;
      if (bank_idx_q == BSEL_W'(NUM_BANKS - 1)) begin
        addr_cnt_d = addr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
    if (dram_to_mem_rst_i) begin
      bank_idx_q <= '0;
      addr_cnt_q <= '0;
    end else begin
      bank_idx_q <= bank_idx_d;
      addr_cnt_q <= addr_cnt_d;
    end
  end

  always_comb begin
    bank_onehot_o             = '0;
    bank_onehot_o[bank_idx_q] = 1'b1;
  end

  assign bank_idx_o = bank_idx_q;
  assign addr_cnt_o = addr_cnt_q;

endmodule

// File: rtl/bram_fill_controller.sv
// Writes packed words into interleaved BRAM banks for one start/done-bracketed load.
// Define FILL_COUNT_EN to add the words_written_o progress output.
module bram_fill_controller
  import bram_fill_controller_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH,
  parameter int NUM_BANKS     = DEFAULT_NUM_BANKS
) (
  input  logic                  clk_i,
  input  logic                  dram_to_mem_rst_i,
  bram_fill_controller_if.slave bus,
  output fill_state_e           state_dbg_o
);

  localparam int BSEL_W  = bank_sel_bits(NUM_BANKS);
  localparam int CNT_W   = word_cnt_bits(ADDR_BITWIDTH, NUM_BANKS);
  localparam int CAP_INT = NUM_BANKS * (2 ** ADDR_BITWIDTH);
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(CAP_INT);

  fill_state_e              state_q, state_d;
  logic [CNT_W-1:0]         target_q, target_d;
  logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
  logic                     err_q, err_d;
  logic [DATA_BITWIDTH-1:0] data_q, data_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [NUM_BANKS-1:0]     we_q, we_d;

  logic                     gen_clear, gen_advance;
  logic [BSEL_W-1:0]        bank_idx;
  logic [ADDR_BITWIDTH-1:0] addr_cnt;
  logic [NUM_BANKS-1:0]     bank_onehot;

  bram_interleave_addr_gen #(
    .ADDR_BITWIDTH (ADDR_BITWIDTH),
    .NUM_BANKS     (NUM_BANKS)
  ) u_addr_gen (
    .clk_i             (clk_i),
    .dram_to_mem_rst_i (dram_to_mem_rst_i),
    .clear_i           (gen_clear),
    .advance_i         (gen_advance),
    .bank_idx_o        (bank_idx),
    .addr_cnt_o        (addr_cnt),
    .bank_onehot_o     (bank_onehot)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    word_cnt_d  = word_cnt_q;
    err_d       = err_q;
    data_d      = data_q;
    addr_d      = addr_q;
    we_d        = '0;
    gen_clear   = 1'b0;
    gen_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A word arriving here has no load to belong to, even alongside start_i.
        if (bus.word_valid_i) err_d = 1'b1;
        if (bus.start_i) begin
          gen_clear  = 1'b1;
          word_cnt_d = '0;
          if (bus.total_words_i > CAPACITY) begin
            target_d = CAPACITY;
            err_d    = 1'b1;
          end else begin
            target_d = bus.total_words_i;
          end
          state_d = (bus.total_words_i == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.word_valid_i) begin
          gen_advance = 1'b1;
          we_d        = bank_onehot;
          data_d      = bus.word_i;
          addr_d      = addr_cnt;
          word_cnt_d  = word_cnt_q + 1'b1;
          if (word_cnt_d == target_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.word_valid_i) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
    if (dram_to_mem_rst_i) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      we_q       <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
    end
  end

  assign bus.bram_data_o = data_q;
  assign bus.bram_addr_o = addr_q;
  assign bus.bram_we_o   = we_q;
  assign bus.busy_o      = (state_q == ST_FILL);
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.err_o       = err_q;
  assign state_dbg_o     = state_q;

`ifdef FILL_COUNT_EN
  // Each accepted word is presented as a write on the following edge, so the
  // accepted-word count equals the writes already presented.
  assign bus.words_written_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_bram_fill_controller.sv
// Randomized bench for bram_fill_controller against a word-index reference model.
module tb_bram_fill_controller;
  import bram_fill_controller_pkg::*;

  localparam int DW  = 163;
  localparam int AW  = 4;
  localparam int NB  = 4;
  localparam int CW  = AW + $clog2(NB) + 1;
  localparam int CAP = NB * (2 ** AW);

  logic        clk;
  logic        rst;
  fill_state_e state_dbg;
  int          n_cmp;
  int          n_fail;
  logic        m_err;

  bram_fill_controller_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_BANKS(NB)) bus ();

  bram_fill_controller #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_BANKS(NB)) dut (
    .clk_i             (clk),
    .dram_to_mem_rst_i (rst),
    .bus               (bus.slave),
    .state_dbg_o       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic drive(input logic st, input logic [CW-1:0] tot, input logic v, input logic [DW-1:0] w);
    bus.start_i       = st;
    bus.total_words_i = tot;
    bus.word_valid_i  = v;
    bus.word_i        = w;
    @(posedge clk);
    #1;
    bus.start_i      = 1'b0;
    bus.word_valid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start_i = 1'b0; bus.total_words_i = '0; bus.word_valid_i = 1'b0; bus.word_i = '0;
    rst = 1'b1;
    #3;
    m_err = 1'b0;
    n_cmp++; if (bus.bram_we_o !== '0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.bram_we_o); end
    n_cmp++; if (bus.bram_addr_o !== '0 || bus.bram_data_o !== '0) begin n_fail++; $display("FAIL reset_addr_data: got addr=%0d data=%h expected 0", bus.bram_addr_o, bus.bram_data_o); end
    n_cmp++; if ({bus.busy_o, bus.done_o, bus.err_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/done/err=%b expected 000", {bus.busy_o, bus.done_o, bus.err_o}); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One full load: word k must land on bank k%NB, address k/NB, one cycle after its valid.
  task automatic test_load(input string tag, input int tot, input int min_gap, input int max_gap, input bit seq_data);
    int            eff;
    logic [DW-1:0] w;
    logic [NB-1:0] exp_we;
    eff = (tot > CAP) ? CAP : tot;
    drive(1'b1, CW'(tot), 1'b0, '0);
    if (tot > CAP) m_err = 1'b1;
    n_cmp++; if (bus.err_o !== m_err) begin n_fail++; $display("FAIL %s start_err: got %b expected %b", tag, bus.err_o, m_err); end
    n_cmp++; if (bus.busy_o !== (eff != 0)) begin n_fail++; $display("FAIL %s start_busy: got %b expected %b", tag, bus.busy_o, eff != 0); end
    n_cmp++; if (bus.done_o !== (eff == 0) || bus.bram_we_o !== '0) begin n_fail++; $display("FAIL %s start_done_we: got done=%b we=%b expected done=%b we=0", tag, bus.done_o, bus.bram_we_o, eff == 0); end
    for (int k = 0; k < eff; k++) begin
      repeat ($urandom_range(max_gap, min_gap)) begin
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (bus.bram_we_o !== '0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL %s gap before %0d: got we=%b done=%b busy=%b expected we=0 done=0 busy=1", tag, k, bus.bram_we_o, bus.done_o, bus.busy_o); end
      end
      w      = seq_data ? DW'(k + 1) : rand_word();
      exp_we = NB'(1) << (k % NB);
      drive(1'b0, '0, 1'b1, w);
      n_cmp++; if (bus.bram_we_o !== exp_we || bus.bram_addr_o !== AW'(k / NB) || bus.bram_data_o !== w) begin
        n_fail++; $display("FAIL %s write %0d: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h", tag, k, bus.bram_we_o, bus.bram_addr_o, bus.bram_data_o, exp_we, k / NB, w);
      end
      n_cmp++; if (bus.done_o !== (k == eff - 1)) begin n_fail++; $display("FAIL %s done at %0d: got %b expected %b", tag, k, bus.done_o, k == eff - 1); end
    end
    drive(1'b0, '0, 1'b0, '0);
    n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b00 || bus.bram_we_o !== '0 || bus.err_o !== m_err) begin
      n_fail++; $display("FAIL %s after_done: got busy=%b done=%b we=%b err=%b expected 0 0 0 %b", tag, bus.busy_o, bus.done_o, bus.bram_we_o, bus.err_o, m_err);
    end
    if (tot > CAP) begin
      repeat (2) begin
        drive(1'b0, '0, 1'b1, rand_word());
        n_cmp++; if (bus.bram_we_o !== '0 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL %s extra_word: got we=%b done=%b expected 0 0", tag, bus.bram_we_o, bus.done_o); end
      end
    end
  endtask

  task automatic test_stray_and_restart();
    logic [DW-1:0] w;
    drive(1'b0, '0, 1'b1, rand_word());
    m_err = 1'b1;
    n_cmp++; if (bus.bram_we_o !== '0 || bus.err_o !== m_err) begin n_fail++; $display("FAIL stray_word: got we=%b err=%b expected 0 1", bus.bram_we_o, bus.err_o); end
    drive(1'b1, CW'(3), 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      w = rand_word();
      // A second start alongside word 1 must not reload the target of 3.
      drive(k == 1, CW'(10), 1'b1, w);
      n_cmp++; if (bus.bram_we_o !== NB'(1) << k || bus.bram_addr_o !== '0 || bus.bram_data_o !== w) begin
        n_fail++; $display("FAIL midfill_write %0d: got we=%b addr=%0d expected we=%b addr=0", k, bus.bram_we_o, bus.bram_addr_o, NB'(1) << k);
      end
      n_cmp++; if (bus.done_o !== (k == 2)) begin n_fail++; $display("FAIL midfill_done %0d: got %b expected %b", k, bus.done_o, k == 2); end
    end
    drive(1'b0, '0, 1'b0, '0);
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.err_o !== m_err) begin n_fail++; $display("FAIL midfill_end: got busy=%b err=%b expected 0 1", bus.busy_o, bus.err_o); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] w;
    drive(1'b1, CW'(8), 1'b0, '0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, rand_word());
    rst = 1'b1;
    #2;
    m_err = 1'b0;
    n_cmp++; if (bus.bram_we_o !== '0 || bus.bram_addr_o !== '0 || bus.bram_data_o !== '0) begin n_fail++; $display("FAIL async_reset_bus: got we=%b addr=%0d data=%h expected 0", bus.bram_we_o, bus.bram_addr_o, bus.bram_data_o); end
    n_cmp++; if ({bus.busy_o, bus.done_o, bus.err_o} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 000", {bus.busy_o, bus.done_o, bus.err_o}); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      drive(1'b0, '0, 1'b0, '0);
      n_cmp++; if (bus.done_o !== 1'b0 || bus.bram_we_o !== '0) begin n_fail++; $display("FAIL abandoned_load: got done=%b we=%b expected 0 0", bus.done_o, bus.bram_we_o); end
    end
    drive(1'b1, CW'(2), 1'b1, rand_word());
    m_err = 1'b1;
    n_cmp++; if (bus.bram_we_o !== '0 || bus.err_o !== m_err || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL start_with_word: got we=%b err=%b busy=%b expected 0 1 1", bus.bram_we_o, bus.err_o, bus.busy_o); end
    for (int k = 0; k < 2; k++) begin
      w = rand_word();
      drive(1'b0, '0, 1'b1, w);
      n_cmp++; if (bus.bram_we_o !== NB'(1) << k || bus.bram_addr_o !== '0 || bus.bram_data_o !== w || bus.done_o !== (k == 1)) begin
        n_fail++; $display("FAIL restart_write %0d: got we=%b addr=%0d done=%b expected we=%b addr=0 done=%b", k, bus.bram_we_o, bus.bram_addr_o, bus.done_o, NB'(1) << k, k == 1);
      end
    end
    drive(1'b0, '0, 1'b0, '0);
`ifdef FILL_COUNT_EN
    n_cmp++; if (bus.words_written_o !== CW'(2)) begin n_fail++; $display("FAIL words_written: got %0d expected 2", bus.words_written_o); end
`endif
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL restart_end: got busy=%b done=%b expected 0 0", bus.busy_o, bus.done_o); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_err  = 1'b0;
    rst    = 1'b0;
    test_reset();
    test_load("basic6", 6, 0, 0, 1'b1);
    test_load("zero", 0, 0, 0, 1'b0);
    test_load("full64_gapped", 64, 2, 2, 1'b0);
    test_load("clamp100", 100, 0, 1, 1'b0);
    test_reset();
    test_stray_and_restart();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
